wb_slave_regfile: RTL and testbench

Wishbone classic-cycle slave (responder) with a register file of 2**DEPTH_LOG2 words. It terminates single and back-to-back cycles issued by the team's Wishbone master. Termination can be ack, err or rty, after a programmable number of wait states. Each word carries a data tag, written with the word and returned on reads, so master-side tag and data checks close the loop.

---
 rtl/wb_slave_regfile.sv | 165 ++++++++++++++++
 tb/tb_wb_slave_regfile.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave with a tagged register file and programmable
// wait states; terminates each transfer with ack, err or rty.
module wb_slave_regfile #(
  parameter int                   ADR_WIDTH   = 32,
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   SEL_WIDTH   = 4,
  parameter int                   TAG_WIDTH   = 4,
  parameter int                   DEPTH_LOG2  = 4,
  parameter logic [ADR_WIDTH-1:0] BASE_ADR    = 32'h0000_0100,
  parameter int                   WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [TAG_WIDTH-1:0]  tgd_i,
  input  logic [TAG_WIDTH-1:0]  tga_i,
  input  logic [TAG_WIDTH-1:0]  tgc_i,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  input  logic                  busy_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [TAG_WIDTH-1:0]  tgd_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  rty_o
);

  localparam int                 WORDS    = 2**DEPTH_LOG2;
  localparam logic [ADR_WIDTH:0] ADR_LO   = {1'b0, BASE_ADR};
  localparam logic [ADR_WIDTH:0] ADR_HI   = ADR_LO + (ADR_WIDTH+1)'(4*WORDS);
  localparam logic [3:0]         CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES-1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, TERM} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [DATA_WIDTH-1:0]   mem     [WORDS];
  logic [TAG_WIDTH-1:0]    tag_mem [WORDS];

  logic                    lat_we;
  logic                    lat_err;
  logic [DATA_WIDTH-1:0]   lat_dat;
  logic [SEL_WIDTH-1:0]    lat_sel;
  logic [TAG_WIDTH-1:0]    lat_tgd;
  logic [DEPTH_LOG2-1:0]   lat_idx;

  logic                    accept;
  logic                    in_range;
  logic                    bad;
  logic [ADR_WIDTH-1:0]    offset;
  logic                    fire_term;

  logic                    t_we;
  logic                    t_err;
  logic [DATA_WIDTH-1:0]   t_dat;
  logic [SEL_WIDTH-1:0]    t_sel;
  logic [TAG_WIDTH-1:0]    t_tgd;
  logic [DEPTH_LOG2-1:0]   t_idx;

  logic                    unused_ok;

  assign accept   = cyc_i & stb_i;
  assign in_range = ({1'b0, adr_i} >= ADR_LO) && ({1'b0, adr_i} < ADR_HI);
  assign offset   = adr_i - BASE_ADR;
  assign bad      = !in_range || (adr_i[1:0] != 2'b00) || (sel_i == '0);

  // A zero-wait termination happens in IDLE straight from the bus inputs;
  // otherwise the values latched at acceptance are used.
  assign t_we  = (state == IDLE) ? we_i  : lat_we;
  assign t_err = (state == IDLE) ? bad   : lat_err;
  assign t_dat = (state == IDLE) ? dat_i : lat_dat;
  assign t_sel = (state == IDLE) ? sel_i : lat_sel;
  assign t_tgd = (state == IDLE) ? tgd_i : lat_tgd;
  assign t_idx = (state == IDLE) ? offset[DEPTH_LOG2+1:2] : lat_idx;

  assign unused_ok = ^{tga_i, tgc_i, offset};

  always_comb begin
    fire_term = 1'b0;
    case (state)
      IDLE:    fire_term = accept && (bad || !busy_i) && (WAIT_STATES == 0);
      WAIT:    fire_term = accept && (wait_cnt == '0);
      default: fire_term = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      rty_o    <= 1'b0;
      dat_o    <= '0;
      tgd_o    <= '0;
      lat_we   <= 1'b0;
      lat_err  <= 1'b0;
      lat_dat  <= '0;
      lat_sel  <= '0;
      lat_tgd  <= '0;
      lat_idx  <= '0;
      for (int i = 0; i < WORDS; i++) begin
        mem[i]     <= '0;
        tag_mem[i] <= '0;
      end
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;

      if (fire_term) begin
        if (t_err) begin
          err_o <= 1'b1;
        end else begin
          ack_o <= 1'b1;
          if (t_we) begin
            for (int b = 0; b < SEL_WIDTH; b++) begin
              if (t_sel[b]) mem[t_idx][b*8 +: 8] <= t_dat[b*8 +: 8];
            end
            tag_mem[t_idx] <= t_tgd;
          end else begin
            dat_o <= mem[t_idx];
            tgd_o <= tag_mem[t_idx];
          end
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            lat_we  <= we_i;
            lat_err <= bad;
            lat_dat <= dat_i;
            lat_sel <= sel_i;
            lat_tgd <= tgd_i;
            lat_idx <= offset[DEPTH_LOG2+1:2];
            if (!bad && busy_i) begin
              rty_o <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= TERM;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!accept) begin
            state <= IDLE;
          end else if (wait_cnt == '0) begin
            state <= TERM;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        TERM:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Self-checking bench for wb_slave_regfile: directed scenarios plus random
// transfers compared against an array-based model of the register file.
module tb_wb_slave_regfile;

  localparam int          WS   = 1;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic [3:0]  tgd_i;
  logic [3:0]  tga_i;
  logic [3:0]  tgc_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        busy_i;
  logic [31:0] dat_o;
  logic [3:0]  tgd_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  int compare_count = 0;
  int fail_count    = 0;
  int edge_count    = 0;

  logic [31:0] model_mem [16];
  logic [3:0]  model_tag [16];
  logic [31:0] model_dat;
  logic [3:0]  model_tgd;

  wb_slave_regfile #(.WAIT_STATES(WS)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i),
    .tgd_i(tgd_i), .tga_i(tga_i), .tgc_i(tgc_i), .we_i(we_i), .stb_i(stb_i),
    .cyc_i(cyc_i), .busy_i(busy_i), .dat_o(dat_o), .tgd_o(tgd_o),
    .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      model_tag[i] = '0;
    end
    model_dat = '0;
    model_tgd = '0;
  endtask

  // 0 = ack, 1 = err, 2 = rty, decided purely from the address map rules
  function automatic int classify(input logic [31:0] adr, input logic [3:0] sel, input logic busy);
    if (adr < BASE || adr >= BASE + 32'd64 || adr[1:0] != 2'b00 || sel == 4'h0) return 1;
    if (busy) return 2;
    return 0;
  endfunction

  // One complete classic-cycle transfer, checked against the model
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] tgd,
                               input logic we, input logic busy);
    int          kind;
    int          lat;
    int          idx;
    logic        seen;
    logic [2:0]  term;
    logic [2:0]  exp_term;
    kind     = classify(adr, sel, busy);
    exp_term = (kind == 0) ? 3'b001 : (kind == 1) ? 3'b010 : 3'b100;
    idx      = int'((adr - BASE) >> 2) & 15;
    @(negedge clk);
    adr_i = adr; dat_i = dat; sel_i = sel; tgd_i = tgd; we_i = we; busy_i = busy;
    tga_i = 4'($urandom); tgc_i = 4'($urandom);
    cyc_i = 1'b1; stb_i = 1'b1;
    seen = 1'b0; lat = -1; term = 3'b000;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack_o || err_o || rty_o) begin
        seen = 1'b1;
        lat  = k;
        term = {rty_o, err_o, ack_o};
      end
    end
    cyc_i = 1'b0; stb_i = 1'b0; busy_i = 1'b0;
    checkOutput("term_seen", 32'(seen), 32'd1);
    checkOutput("term_kind", 32'(term), 32'(exp_term));
    checkOutput("term_latency", lat, (kind == 2) ? 0 : WS);
    if (kind == 0) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[idx][b*8 +: 8] = dat[b*8 +: 8];
        model_tag[idx] = tgd;
      end else begin
        model_dat = model_mem[idx];
        model_tgd = model_tag[idx];
      end
    end
    checkOutput("dat_o", dat_o, model_dat);
    checkOutput("tgd_o", 32'(tgd_o), 32'(model_tgd));
    @(negedge clk);
    checkOutput("term_one_clock", 32'({rty_o, err_o, ack_o}), 32'd0);
  endtask

  task automatic readWord(input logic [31:0] adr);
    applyStimulus(adr, 32'($urandom), 4'hF, 4'($urandom), 1'b0, 1'b0);
  endtask

  // Strobe held high across four writes; address advances once ack is seen
  task automatic backToBack();
    int   ack_at [4];
    logic seen;
    @(negedge clk);
    adr_i = BASE; dat_i = 32'd1; sel_i = 4'hF; tgd_i = 4'd1; we_i = 1'b1; busy_i = 1'b0;
    cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      ack_at[i] = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (ack_o) begin
          seen = 1'b1;
          ack_at[i] = edge_count;
        end
      end
      checkOutput("b2b_ack", 32'(seen), 32'd1);
      model_mem[i] = 32'(i + 1);
      model_tag[i] = 4'(i + 1);
      if (i < 3) begin
        adr_i = BASE + 32'(4 * (i + 1));
        dat_i = 32'(i + 2);
        tgd_i = 4'(i + 2);
      end else begin
        cyc_i = 1'b0; stb_i = 1'b0;
      end
    end
    for (int i = 1; i < 4; i++)
      checkOutput("b2b_spacing", ack_at[i] - ack_at[i-1], WS + 2);
    @(negedge clk);
  endtask

  task automatic abortWrite();
    int ack_cnt;
    @(negedge clk);
    adr_i = BASE + 32'h0C; dat_i = 32'hCAFE_F00D; sel_i = 4'hF; tgd_i = 4'hA;
    we_i = 1'b1; busy_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(negedge clk);
    cyc_i = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack_o || err_o || rty_o) ack_cnt++;
    end
    stb_i = 1'b0;
    checkOutput("abort_no_term", ack_cnt, 0);
  endtask

  task automatic stbWithoutCyc();
    int term_cnt;
    @(negedge clk);
    adr_i = BASE; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b0; stb_i = 1'b1;
    term_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack_o || err_o || rty_o) term_cnt++;
    end
    stb_i = 1'b0;
    checkOutput("stb_no_cyc", term_cnt, 0);
  endtask

  task automatic resetDuringWait();
    @(negedge clk);
    adr_i = BASE + 32'h04; dat_i = 32'h1357_9BDF; sel_i = 4'hF; tgd_i = 4'h3;
    we_i = 1'b1; busy_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_dat_o", dat_o, 32'd0);
    checkOutput("rst_async_tgd_o", 32'(tgd_o), 32'd0);
    checkOutput("rst_async_term", 32'({rty_o, err_o, ack_o}), 32'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] adr;
    int          r;
    rst_n = 1'b0;
    adr_i = '0; dat_i = '0; sel_i = '0; tgd_i = '0; tga_i = '0; tgc_i = '0;
    we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; busy_i = 1'b0;
    clearModel();
    repeat (3) @(negedge clk);
    checkOutput("reset_dat_o", dat_o, 32'd0);
    checkOutput("reset_term", 32'({rty_o, err_o, ack_o, tgd_o}), 32'd0);
    rst_n = 1'b1;
    readWord(BASE);

    applyStimulus(BASE + 32'h04, 32'hDEAD_BEEF, 4'hF, 4'h7, 1'b1, 1'b0);
    readWord(BASE + 32'h04);
    checkOutput("t1_readback", dat_o, 32'hDEAD_BEEF);

    applyStimulus(BASE + 32'h08, 32'h1122_3344, 4'hF, 4'h2, 1'b1, 1'b0);
    applyStimulus(BASE + 32'h08, 32'hAABB_CCDD, 4'b0101, 4'h5, 1'b1, 1'b0);
    readWord(BASE + 32'h08);
    checkOutput("t2_partial", dat_o, 32'h11BB_33DD);

    applyStimulus(32'h0000_0140, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b1, 1'b0);
    applyStimulus(32'h0000_0102, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b1, 1'b0);
    applyStimulus(BASE + 32'h08, 32'hFFFF_FFFF, 4'h0, 4'hF, 1'b1, 1'b0);
    applyStimulus(32'h0000_00FC, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b0, 1'b0);
    readWord(BASE + 32'h08);

    applyStimulus(BASE + 32'h0C, 32'h0BAD_0BAD, 4'hF, 4'h9, 1'b1, 1'b1);
    readWord(BASE + 32'h0C);
    applyStimulus(BASE + 32'h0C, 32'h600D_600D, 4'hF, 4'h9, 1'b1, 1'b0);
    readWord(BASE + 32'h0C);

    backToBack();
    for (int i = 0; i < 4; i++) readWord(BASE + 32'(4 * i));

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       adr = BASE + 32'(4 * $urandom_range(0, 15));
      else if (r == 7) adr = ($urandom_range(0, 1) == 0) ? BASE + 32'h40 + 32'(4 * $urandom_range(0, 8)) : $urandom;
      else if (r == 8) adr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else             adr = BASE - 32'(4 * $urandom_range(1, 4));
      applyStimulus(adr, $urandom, 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    abortWrite();
    readWord(BASE + 32'h0C);
    stbWithoutCyc();

    readWord(BASE + 32'h08);
    resetDuringWait();
    readWord(BASE + 32'h04);
    readWord(BASE + 32'h08);
    readWord(BASE + 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
